// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection request scheduler
// and the light controller it feeds.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b100;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_E = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        EMG_WAIT,
        EMG_SERVE,
        PED_WAIT,
        PED_SERVE
    } sched_state_t;

    typedef enum logic [2:0] {
        ST_NS_GREEN,
        ST_NS_YELLOW,
        ST_NS_ALL_RED,
        ST_EW_GREEN,
        ST_EW_YELLOW,
        ST_EW_ALL_RED
    } state_t;

    // First requesting direction at or after ptr, in N,S,E,W order.
    function automatic logic [1:0] rr_pick(
        input logic [3:0] req,
        input logic [1:0] ptr
    );
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/req_sync_debounce.sv
// Two-flop synchroniser and counting debouncer for a raw push-button,
// with a one-cycle pulse on each accepted rising edge.
module req_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_an,
    input  logic btn_raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt tracks consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            s1   <= btn_raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= s2;
                rise  <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_request_scheduler.sv
// Front-end scheduler: debounced pedestrian requests and round-robin
// emergency grants, retired once the controller's lights serve them.
module traffic_request_scheduler
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SERVE_CYCLES    = 4,
    parameter int WAIT_MAX        = 63
) (
    input  logic       clk,
    input  logic       rst_an,
    input  logic       ped_button_raw,
    input  logic [3:0] emerg_req,
    input  logic [2:0] n_lights,
    input  logic [2:0] s_lights,
    input  logic [2:0] e_lights,
    input  logic [2:0] w_lights,
    output logic [3:0] emergency_dir,
    output logic       ped_request,
    output logic       ped_served,
    output logic [3:0] emerg_served,
    output logic       timeout_err,
    output logic       busy
);

    localparam int SW = $clog2(SERVE_CYCLES + 1);

    sched_state_t    state_q;
    sched_state_t    state_d;
    logic [1:0]      grant_q;
    logic [1:0]      grant_d;
    logic [1:0]      ptr_q;
    logic [1:0]      ptr_d;
    logic [1:0]      pick;
    logic [5:0]      wait_q;
    logic [5:0]      wait_d;
    logic [SW-1:0]   serve_q;
    logic [SW-1:0]   serve_d;
    logic [3:0]      rearm_q;
    logic [3:0]      rearm_d;
    logic [3:0]      rearm_set;
    logic [3:0]      eligible;
    logic [3:0]      grant_oh;
    logic [3:0]      dir_d;
    logic [3:0]      esrv_d;
    logic            ped_pending_q;
    logic            ped_pending_d;
    logic            ped_rise;
    logic            ped_clr;
    logic            preq_d;
    logic            psrv_d;
    logic            tmo_d;
    logic            issue;
    logic            granted_green;
    logic            all_red;
    logic [3:0][2:0] lights;

    req_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ped_btn (
        .clk    (clk),
        .rst_an (rst_an),
        .btn_raw(ped_button_raw),
        .rise   (ped_rise)
    );

    assign lights        = {w_lights, e_lights, s_lights, n_lights};
    assign eligible      = emerg_req & ~rearm_q;
    assign pick          = rr_pick(eligible, ptr_q);
    assign grant_oh      = 4'b0001 << grant_q;
    assign granted_green = (lights[grant_q] == LIGHT_GREEN);
    assign all_red       = (n_lights == LIGHT_RED) && (s_lights == LIGHT_RED)
                        && (e_lights == LIGHT_RED) && (w_lights == LIGHT_RED);
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        serve_d   = serve_q;
        dir_d     = emergency_dir;
        esrv_d    = '0;
        psrv_d    = 1'b0;
        tmo_d     = 1'b0;
        rearm_set = '0;
        ped_clr   = 1'b0;
        issue     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|eligible) issue = 1'b1;
                else if (ped_pending_q) state_d = PED_WAIT;
            end
            EMG_WAIT: begin
                if (granted_green) begin
                    state_d = EMG_SERVE;
                    serve_d = SW'(1);
                end else if (wait_q == 6'(WAIT_MAX)) begin
                    state_d   = IDLE;
                    dir_d     = '0;
                    tmo_d     = 1'b1;
                    rearm_set = grant_oh;
                    ptr_d     = grant_q + 2'd1;
                end
            end
            EMG_SERVE: begin
                if (serve_q == SW'(SERVE_CYCLES)) begin
                    state_d   = IDLE;
                    dir_d     = '0;
                    esrv_d    = grant_oh;
                    rearm_set = grant_oh;
                    ptr_d     = grant_q + 2'd1;
                end else if (!granted_green) begin
                    state_d = EMG_WAIT;
                end else begin
                    serve_d = serve_q + 1'b1;
                end
            end
            PED_WAIT: begin
                if (|eligible) begin
                    issue = 1'b1;
                end else if (all_red) begin
                    state_d = PED_SERVE;
                    serve_d = SW'(1);
                end else if (wait_q == 6'(WAIT_MAX)) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
            end
            PED_SERVE: begin
                if (|eligible) begin
                    issue = 1'b1;
                end else if (serve_q == SW'(SERVE_CYCLES)) begin
                    state_d = IDLE;
                    psrv_d  = 1'b1;
                    ped_clr = 1'b1;
                end else if (!all_red) begin
                    state_d = PED_WAIT;
                end else begin
                    serve_d = serve_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new grant (from IDLE or by preempting a pedestrian phase)
        if (issue) begin
            state_d = EMG_WAIT;
            grant_d = pick;
            dir_d   = 4'b0001 << pick;
        end

        if (issue || (state_q == IDLE && state_d == PED_WAIT))
            wait_d = '0;
        else if (state_q != IDLE && wait_q != 6'(WAIT_MAX))
            wait_d = wait_q + 6'd1;
        else
            wait_d = wait_q;

        rearm_d       = (rearm_q & emerg_req) | rearm_set;
        ped_pending_d = ped_clr ? 1'b0 : (ped_pending_q | ped_rise);
        preq_d        = ped_pending_q
                     && (state_d == PED_WAIT || state_d == PED_SERVE);
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q       <= IDLE;
            grant_q       <= DIR_N;
            ptr_q         <= DIR_N;
            wait_q        <= '0;
            serve_q       <= '0;
            rearm_q       <= '0;
            ped_pending_q <= 1'b0;
            emergency_dir <= '0;
            ped_request   <= 1'b0;
            ped_served    <= 1'b0;
            emerg_served  <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            wait_q        <= wait_d;
            serve_q       <= serve_d;
            rearm_q       <= rearm_d;
            ped_pending_q <= ped_pending_d;
            emergency_dir <= dir_d;
            ped_request   <= preq_d;
            ped_served    <= psrv_d;
            emerg_served  <= esrv_d;
            timeout_err   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_traffic_request_scheduler.sv
// Directed and randomised checks of the request scheduler against a
// behavioural model of its request/serve rules.
module tb_traffic_request_scheduler;

    localparam logic [2:0] RED = 3'b001;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b100;

    logic       clk = 1'b0;
    logic       rst_an;
    logic       ped_button_raw;
    logic [3:0] emerg_req;
    logic [2:0] n_lights, s_lights, e_lights, w_lights;
    logic [3:0] emergency_dir;
    logic       ped_request;
    logic       ped_served;
    logic [3:0] emerg_served;
    logic       timeout_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_to;
    bit ever_preq;

    traffic_request_scheduler dut (
        .clk           (clk),
        .rst_an        (rst_an),
        .ped_button_raw(ped_button_raw),
        .emerg_req     (emerg_req),
        .n_lights      (n_lights),
        .s_lights      (s_lights),
        .e_lights      (e_lights),
        .w_lights      (w_lights),
        .emergency_dir (emergency_dir),
        .ped_request   (ped_request),
        .ped_served    (ped_served),
        .emerg_served  (emerg_served),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1/2 emergency wait/serve,
    // 3/4 pedestrian wait/serve.
    bit   rawq[$];
    bit   dsq[$];
    bit   m_lvl, m_rise, m_pend;
    int   m_mode, m_g, m_ptr, m_wait, m_serve;
    bit [3:0] m_rearm;
    bit [3:0] x_dir, x_esrv;
    bit   x_preq, x_psrv, x_to, x_busy;

    task automatic model_reset();
        rawq = '{0, 0};
        dsq = '{0, 0, 0, 0};
        m_lvl = 0; m_rise = 0; m_pend = 0;
        m_mode = 0; m_g = 0; m_ptr = 0; m_wait = 0; m_serve = 0;
        m_rearm = 0;
        x_dir = 0; x_esrv = 0;
        x_preq = 0; x_psrv = 0; x_to = 0; x_busy = 0;
    endtask

    task automatic model_edge();
        bit [2:0] lt[4];
        bit syn, nlvl, npend, green, allred, clrp, issue;
        bit [3:0] elig, rset;
        int pick, nmode, nwait, nserve, nptr;
        lt[0] = n_lights; lt[1] = s_lights;
        lt[2] = e_lights; lt[3] = w_lights;
        syn = rawq.pop_front();
        rawq.push_back(ped_button_raw);
        void'(dsq.pop_front());
        dsq.push_back(syn);
        nlvl = m_lvl;
        if (dsq[0] != m_lvl && dsq[1] != m_lvl &&
            dsq[2] != m_lvl && dsq[3] != m_lvl) nlvl = !m_lvl;
        elig = emerg_req & ~m_rearm;
        pick = -1;
        for (int k = 0; k < 4; k++)
            if (pick < 0 && elig[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
        green = (lt[m_g] == GRN);
        allred = (lt[0] == RED && lt[1] == RED && lt[2] == RED && lt[3] == RED);
        x_esrv = 0; x_psrv = 0; x_to = 0;
        rset = 0; clrp = 0; issue = 0;
        nmode = m_mode; nserve = m_serve; nptr = m_ptr;
        case (m_mode)
            0: if (pick >= 0) issue = 1; else if (m_pend) nmode = 3;
            1: if (green) begin
                   nmode = 2; nserve = 1;
               end else if (m_wait == 63) begin
                   nmode = 0; x_to = 1; x_dir = 0;
                   rset[m_g] = 1; nptr = (m_g + 1) % 4;
               end
            2: if (m_serve == 4) begin
                   nmode = 0; x_dir = 0; x_esrv[m_g] = 1;
                   rset[m_g] = 1; nptr = (m_g + 1) % 4;
               end else if (!green) nmode = 1;
               else nserve = m_serve + 1;
            3: if (pick >= 0) issue = 1;
               else if (allred) begin nmode = 4; nserve = 1; end
               else if (m_wait == 63) begin nmode = 0; x_to = 1; end
            default:
               if (pick >= 0) issue = 1;
               else if (m_serve == 4) begin nmode = 0; x_psrv = 1; clrp = 1; end
               else if (!allred) nmode = 3;
               else nserve = m_serve + 1;
        endcase
        if (issue) begin
            nmode = 1; m_g = pick; x_dir = 4'b0001 << pick;
        end
        if (issue || (m_mode == 0 && nmode == 3)) nwait = 0;
        else if (m_mode != 0 && m_wait < 63) nwait = m_wait + 1;
        else nwait = m_wait;
        x_preq = m_pend && (nmode == 3 || nmode == 4);
        npend = clrp ? 0 : (m_pend | m_rise);
        m_rearm = (m_rearm & emerg_req) | rset;
        m_rise = nlvl && !m_lvl;
        m_lvl = nlvl; m_pend = npend;
        m_mode = nmode; m_wait = nwait; m_serve = nserve; m_ptr = nptr;
        x_busy = (nmode != 0);
    endtask

    function automatic logic [11:0] dut_vec();
        return {emergency_dir, emerg_served, ped_request,
                ped_served, timeout_err, busy};
    endfunction

    function automatic logic [11:0] model_vec();
        return {x_dir, x_esrv, x_preq, x_psrv, x_to, x_busy};
    endfunction

    task automatic check(string tag, logic [11:0] obs, logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle", dut_vec(), model_vec());
        if (ped_request) ever_preq = 1;
        if (timeout_err) n_to++;
    endtask

    task automatic set_all(logic [2:0] v);
        n_lights = v; s_lights = v; e_lights = v; w_lights = v;
    endtask

    task automatic set_light(int d, logic [2:0] v);
        case (d)
            0: n_lights = v;
            1: s_lights = v;
            2: e_lights = v;
            default: w_lights = v;
        endcase
    endtask

    task automatic random_lights();
        int r;
        r = $urandom_range(5);
        if (r == 0) begin
            set_all(RED);
        end else if (r <= 4) begin
            set_all(RED);
            set_light(r - 1, GRN);
        end else begin
            for (int d = 0; d < 4; d++)
                set_light(d, 3'b001 << $urandom_range(2));
        end
    endtask

    initial begin
        int bit_i;
        rst_an = 0; ped_button_raw = 0; emerg_req = 0;
        set_all(YEL);
        model_reset();
        #12;
        check("reset", dut_vec(), 12'h000);
        @(negedge clk);
        rst_an = 1;

        // Debounced press, then an all-red phase serves it
        ped_button_raw = 1;
        repeat (10) tick();
        ped_button_raw = 0;
        check("ped_req_up", 12'(ped_request), 12'h001);
        set_all(RED);
        repeat (4) tick();
        set_all(YEL);
        tick();
        check("ped_served", 12'(ped_served), 12'h001);
        check("ped_req_down", 12'(ped_request), 12'h000);

        // Two-cycle glitch must be rejected
        repeat (8) tick();
        ever_preq = 0;
        ped_button_raw = 1;
        repeat (2) tick();
        ped_button_raw = 0;
        repeat (15) tick();
        check("glitch_preq", 12'(ever_preq), 12'h000);
        check("glitch_busy", 12'(busy), 12'h000);

        // All four requesting: N,S,E,W in turn
        emerg_req = 4'hF;
        for (int d = 0; d < 4; d++) begin
            for (int t = 0; t < 10 && emergency_dir == 0; t++) tick();
            check("rr_grant", 12'(emergency_dir), 12'(4'b0001 << d));
            set_light(d, GRN);
            repeat (4) tick();
            set_all(YEL);
            tick();
            check("rr_served", 12'(emerg_served), 12'(4'b0001 << d));
            emerg_req[d] = 0;
            tick();
            emerg_req[d] = 1;
        end
        emerg_req = 0;
        repeat (70) tick();

        // E never sees green: timeout, no re-grant while held
        n_to = 0;
        emerg_req = 4'b0100;
        repeat (70) tick();
        check("to_pulse", 12'(n_to), 12'h001);
        check("to_dir", 12'(emergency_dir), 12'h000);
        repeat (20) tick();
        check("to_no_regrant", 12'(emergency_dir), 12'h000);
        check("to_once", 12'(n_to), 12'h001);
        emerg_req = 0;
        repeat (2) tick();

        // Emergency preempts a waiting pedestrian phase
        ped_button_raw = 1;
        repeat (8) tick();
        ped_button_raw = 0;
        for (int t = 0; t < 10 && !ped_request; t++) tick();
        check("pw_req", 12'(ped_request), 12'h001);
        emerg_req = 4'b0001;
        tick();
        check("preempt_dir", 12'(emergency_dir), 12'h001);
        check("preempt_preq", 12'(ped_request), 12'h000);
        set_light(0, GRN);
        repeat (4) tick();
        set_all(YEL);
        emerg_req = 0;
        tick();
        check("preempt_served", 12'(emerg_served), 12'h001);
        tick();
        check("ped_reassert", 12'(ped_request), 12'h001);
        set_all(RED);
        repeat (4) tick();
        set_all(YEL);
        tick();
        check("ped_served2", 12'(ped_served), 12'h001);

        // Reset in the middle of serving W
        emerg_req = 4'b1000;
        for (int t = 0; t < 10 && emergency_dir == 0; t++) tick();
        set_light(3, GRN);
        repeat (2) tick();
        #2 rst_an = 0;
        #1;
        check("rst_async", dut_vec(), 12'h000);
        model_reset();
        @(negedge clk);
        rst_an = 1;
        set_all(YEL);
        for (int t = 0; t < 10 && emergency_dir == 0; t++) tick();
        check("regrant_w", 12'(emergency_dir), 12'h008);
        set_light(3, GRN);
        repeat (6) tick();
        emerg_req = 0;
        set_all(YEL);
        repeat (4) tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) begin
                bit_i = $urandom_range(3);
                emerg_req[bit_i] = ~emerg_req[bit_i];
            end
            if ($urandom_range(11) == 0) ped_button_raw = ~ped_button_raw;
            if ($urandom_range(3) == 0) random_lights();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_request_scheduler.md
Name: traffic_request_scheduler

Overview:
- Front-end request scheduler for the 4-way intersection light controller.
- Synchronises and debounces the raw pedestrian button, and latches pending requests.
- Arbitrates concurrent emergency-vehicle requests round-robin, then drives the controller's `emergency_dir` / `ped_request` inputs.
- Monitors the controller's light outputs to decide when each request has been served, then releases it.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples before a button level is accepted.
- SERVE_CYCLES, 4: consecutive cycles a served condition must hold before the request is retired.
- WAIT_MAX, 63: cycles a granted request may wait for service before it is dropped with an error (6-bit counter).

Ports:
- clk  in  1  system clock
- rst_an  in  1  reset, asynchronous assert, active-low
- ped_button_raw  in  1  asynchronous pedestrian push-button
- emerg_req  in  4  level emergency requests, bit order [0]=N [1]=S [2]=E [3]=W
- n_lights  in  3  controller north lights (RED=001, YELLOW=010, GREEN=100)
- s_lights  in  3  controller south lights
- e_lights  in  3  controller east lights
- w_lights  in  3  controller west lights
- emergency_dir  out  4  one-hot or zero grant to controller, same bit order
- ped_request  out  1  pedestrian request to controller
- ped_served  out  1  one-cycle pulse when a pedestrian phase is retired
- emerg_served  out  4  one-cycle one-hot pulse when an emergency grant is retired
- timeout_err  out  1  one-cycle pulse when a grant is dropped unserved
- busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (`rst_an` low, asynchronous):
  - All outputs 0; FSM state IDLE.
  - `ped_pending`=0; RR pointer=N; `rearm_mask`=0000; counters=0; synchroniser/debouncer cleared to 0.
- Pedestrian input path:
  - `ped_button_raw` passes through a 2-flop synchroniser, then the debouncer.
  - Debounced level changes only after DEBOUNCE_CYCLES identical synchronised samples.
  - A debounced rising edge sets `ped_pending`; further presses while pending are ignored.
- Emergency eligibility:
  - `eligible = emerg_req & ~rearm_mask`.
  - A `rearm_mask` bit is set when that direction is retired or timed out.
  - The bit clears on the first cycle that direction's `emerg_req` is sampled low.
- Arbitration: round-robin starting at the pointer (N,S,E,W order). After any retire or timeout the pointer moves to the granted index+1, mod 4.
- Output rules:
  - `emergency_dir` is registered; at most one bit is set.
  - `ped_request` = `ped_pending` AND state is PED_WAIT or PED_SERVE, also registered.
- FSM states: IDLE, EMG_WAIT, EMG_SERVE, PED_WAIT, PED_SERVE.
- IDLE:
  - If `eligible`≠0 → EMG_WAIT: latch the grant, set `emergency_dir`, clear `wait_cnt`.
  - Else if `ped_pending` → PED_WAIT.
  - Emergency wins over pedestrian on the same cycle.
- EMG_WAIT:
  - When the granted direction's lights == GREEN → EMG_SERVE, `serve_cnt`=1.
  - When `wait_cnt`==WAIT_MAX → IDLE: clear grant, set rearm bit, pulse `timeout_err`, advance pointer.
- EMG_SERVE:
  - Granted lights ≠ GREEN → back to EMG_WAIT (`wait_cnt` keeps running).
  - `serve_cnt`==SERVE_CYCLES → IDLE: clear grant, pulse `emerg_served[g]`, set rearm bit, advance pointer.
  - A grant is never changed or withdrawn mid-service because its `emerg_req` dropped.
- PED_WAIT / PED_SERVE:
  - All four lights RED → PED_SERVE and count.
  - Not all RED in PED_SERVE → back to PED_WAIT.
  - `serve_cnt`==SERVE_CYCLES → IDLE: clear `ped_pending`, pulse `ped_served`.
  - WAIT_MAX timeout → IDLE: pulse `timeout_err`; `ped_pending` stays set so the request is retried.
  - Preemption: `eligible`≠0 in PED_WAIT or PED_SERVE → EMG_WAIT immediately. `ped_pending` is kept; `ped_request` drops the next cycle.
- Counters:
  - `wait_cnt` and `serve_cnt` saturate and never wrap.
  - `wait_cnt` increments every cycle outside IDLE and clears on entry to EMG_WAIT or PED_WAIT from IDLE.
- Simultaneous events: a retire/timeout and a new request in the same cycle → the FSM passes through IDLE for one cycle, and the new grant is issued the next cycle.
- Reset mid-operation: grant and pending requests are lost, all outputs return to 0 asynchronously, and pointer returns to N.

Decomposition:
- Package `traffic_pkg`:
  - light encodings RED/YELLOW/GREEN;
  - direction index constants DIR_N..DIR_W;
  - `sched_state_t` enum;
  - the `state_t` of the light controller, moved here.
- Sub-module `req_sync_debounce` (parameter DEBOUNCE_CYCLES): synchroniser + debouncer + rising-edge pulse output.

Test Plan:
- Press `ped_button_raw` for 10 cycles, drive all lights RED 4 cycles → `ped_request`=1 ~7 cycles after press, then `ped_served` pulse; `ped_request`=0.
- 2-cycle glitch on button with DEBOUNCE_CYCLES=4 → `ped_pending` stays 0; `ped_request` never asserts.
- `emerg_req`=1111 held; each grant's lights GREEN 4 cycles, then the request is dropped for 1 cycle to rearm → grants in order N,S,E,W (`emergency_dir` 0001,0010,0100,1000), each followed by the matching `emerg_served` pulse.
- `emerg_req`=0100, E lights never GREEN → after 63 cycles `timeout_err` pulse; `emergency_dir`=0; no re-grant while `emerg_req[2]` held high.
- `ped_pending` in PED_WAIT, then `emerg_req`=0001 → next cycle `emergency_dir`=0001, `ped_request`=0; after N is served, `ped_request` reasserts.
- Grant W active, pull `rst_an` low mid-EMG_SERVE → `emergency_dir`=0 within the same cycle; after release, `emerg_req`=1000 is granted again from IDLE.
